// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - synchronizes and debounces a raw switch level, with rise/fall pulses
module switch_debouncer #(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_COUNT = 250000,
    parameter int CNT_WIDTH    = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic clean_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_chain_d;
    logic [SYNC_STAGES-1:0] sync_chain_q;
    logic                   sync_q;

    state_t                 state_d;
    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   clean_d;
    logic                   clean_q;
    logic                   rise_d;
    logic                   rise_q;
    logic                   fall_d;
    logic                   fall_q;
    logic                   busy_d;
    logic                   busy_q;

    // Shift the raw level into the synchronizer; only stage 0 touches raw_in.
    always_comb begin
        sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], raw_in};
    end

    assign sync_q = sync_chain_q[SYNC_STAGES-1];

    // Synchronizer chain registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain_q <= '0;
        end else begin
            sync_chain_q <= sync_chain_d;
        end
    end

    // Next-state logic: a departure from the clean level must persist for
    // STABLE_COUNT consecutive cycles; any return aborts and discards the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                clean_d = 1'b0;
                cnt_d   = '0;
                if (sync_q) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (!sync_q) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HI: begin
                clean_d = 1'b1;
                cnt_d   = '0;
                if (!sync_q) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (sync_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
                clean_d = 1'b0;
            end
        endcase
        busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
    end

    // FSM state, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - directed bench for switch_debouncer (SYNC_STAGES=2, STABLE_COUNT=4)
module tb_switch_debouncer;

    logic clk;
    logic rst_n;
    logic raw_in;
    logic clean_out;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    int checks;
    int errors;
    int rise_cnt;
    int fall_cnt;

    switch_debouncer #(
        .SYNC_STAGES (2),
        .STABLE_COUNT(4),
        .CNT_WIDTH   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_in    (raw_in),
        .clean_out (clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rise_pulse) rise_cnt++;
        if (fall_pulse) fall_cnt++;
        chk("pulses_exclusive", rise_pulse & fall_pulse, 1'b0);
    endtask

    // Step n edges with raw_in at a fixed level and check one rising transition.
    task automatic run_rise(input string tag);
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk({tag, "_clean"}, clean_out, (e >= 7) ? 1'b1 : 1'b0);
            chk({tag, "_rise"},  rise_pulse, (e == 7) ? 1'b1 : 1'b0);
            chk({tag, "_busy"},  busy, (e >= 3 && e <= 6) ? 1'b1 : 1'b0);
            chk({tag, "_fall"},  fall_pulse, 1'b0);
        end
    endtask

    task automatic run_fall(input string tag);
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk({tag, "_clean"}, clean_out, (e >= 7) ? 1'b0 : 1'b1);
            chk({tag, "_fall"},  fall_pulse, (e == 7) ? 1'b1 : 1'b0);
            chk({tag, "_busy"},  busy, (e >= 3 && e <= 6) ? 1'b1 : 1'b0);
            chk({tag, "_rise"},  rise_pulse, 1'b0);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rise_cnt = 0;
        fall_cnt = 0;
        raw_in   = 1'b0;
        rst_n    = 1'b1;
        #1;
        rst_n    = 1'b0;

        // Reset held while raw_in toggles: all outputs stay low.
        for (int i = 0; i < 6; i++) begin
            raw_in = ~raw_in;
            tick();
            chk("rst_clean", clean_out, 1'b0);
            chk("rst_rise",  rise_pulse, 1'b0);
            chk("rst_fall",  fall_pulse, 1'b0);
            chk("rst_busy",  busy, 1'b0);
        end
        raw_in = 1'b0;
        rst_n  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_clean", clean_out, 1'b0);
            chk("idle_busy",  busy, 1'b0);
        end

        // Clean rise.
        rise_cnt = 0;
        raw_in   = 1'b1;
        run_rise("rise");
        chk("rise_once", rise_cnt == 1, 1'b1);

        // Clean fall.
        fall_cnt = 0;
        rise_cnt = 0;
        raw_in   = 1'b0;
        run_fall("fall");
        chk("fall_once", fall_cnt == 1, 1'b1);
        chk("fall_no_rise", rise_cnt == 0, 1'b1);

        // Bounce: high 3, low 2, then held high; final rising sample is edge 6.
        rise_cnt = 0;
        for (int e = 1; e <= 14; e++) begin
            raw_in = (e <= 3 || e >= 6) ? 1'b1 : 1'b0;
            tick();
            chk("bounce_clean", clean_out, (e >= 12) ? 1'b1 : 1'b0);
            chk("bounce_rise",  rise_pulse, (e == 12) ? 1'b1 : 1'b0);
        end
        chk("bounce_once", rise_cnt == 1, 1'b1);

        // Return low to set up the reset-mid-count case.
        raw_in = 1'b0;
        run_fall("fall2");

        // Reset mid-count: asserted between edges after edge 4, must clear busy at once.
        rise_cnt = 0;
        raw_in   = 1'b1;
        for (int e = 1; e <= 4; e++) tick();
        chk("midcnt_busy_before", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy",  busy, 1'b0);
        chk("async_clean", clean_out, 1'b0);
        tick();
        tick();
        chk("midcnt_no_pulse", rise_cnt == 0, 1'b1);
        rst_n = 1'b1;
        run_rise("post_rst");
        chk("post_rst_once", rise_cnt == 1, 1'b1);

        // Back to low, then repeated single-cycle glitches must be rejected.
        raw_in = 1'b0;
        run_fall("fall3");
        rise_cnt = 0;
        fall_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            raw_in = (i % 3 == 0) ? 1'b1 : 1'b0;
            tick();
            chk("glitch_clean", clean_out, 1'b0);
            chk("glitch_rise",  rise_pulse, 1'b0);
        end
        chk("glitch_no_pulse", (rise_cnt == 0) && (fall_cnt == 0), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
